// File: rtl/vga_band_pattern_if.sv
// Pixel-source bus between the vga timing stage (master) and the band pattern generator (slave).
// Carries the clock enable, fetch/vsync strobes and the registered colour/position outputs.
interface vga_band_pattern_if #(
  parameter int C_BITS_X = 11,
  parameter int C_BITS_Y = 11
);
  logic                clk_pixel_ena;
  logic                fetch_next;
  logic                vga_vsync;
  logic [7:0]          out_red;
  logic [7:0]          out_green;
  logic [7:0]          out_blue;
  logic [1:0]          out_band;
  logic [C_BITS_X-1:0] out_x;
  logic [C_BITS_Y-1:0] out_y;
  logic                out_frame_done;

  modport master (
    output clk_pixel_ena, fetch_next, vga_vsync,
    input  out_red, out_green, out_blue, out_band, out_x, out_y, out_frame_done
  );

  modport slave (
    input  clk_pixel_ena, fetch_next, vga_vsync,
    output out_red, out_green, out_blue, out_band, out_x, out_y, out_frame_done
  );
endinterface

// File: rtl/vga_band_pattern.sv
// Horizontal colour-band pixel source: colour valid 1 clk_pixel after fetch_next, all state frozen when clk_pixel_ena=0.
// Optional macro BAND_SCROLL_EN rotates the starting band by one palette entry at every frame end.
module vga_band_pattern #(
  parameter int C_RES_X      = 1280,
  parameter int C_RES_Y      = 768,
  parameter int C_BAND_LINES = 384,
  parameter int C_NUM_COLORS = 2,
  parameter int C_BITS_X     = 11,
  parameter int C_BITS_Y     = 11
) (
  input  logic                clk_pixel,
  input  logic                rst_n,
  vga_band_pattern_if.slave   bus
);

  localparam int LW = (C_BAND_LINES > 1) ? $clog2(C_BAND_LINES) : 1;
  localparam logic [C_BITS_X-1:0] X_LAST = C_BITS_X'(C_RES_X - 1);
  localparam logic [C_BITS_Y-1:0] Y_LAST = C_BITS_Y'(C_RES_Y - 1);
  localparam logic [LW-1:0]       L_LAST = LW'(C_BAND_LINES - 1);

  logic [C_BITS_X-1:0] x_q, x_d;
  logic [C_BITS_Y-1:0] y_q, y_d;
  logic [LW-1:0]       line_q, line_d;
  logic [1:0]          band_q, band_d;
  logic [1:0]          start_band_q, start_band_d;
  logic [23:0]         rgb_q, rgb_d;
  logic                frame_done_q, frame_done_d;
  logic                vsync_prev_q, vsync_prev_d;

  logic                vsync_rise;
  logic                end_of_line;
  logic                last_pixel;
  logic [1:0]          start_next;

  function automatic logic [1:0] band_inc(input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, b} + 3'd1;
    if (s >= 3'(C_NUM_COLORS)) begin
      return 2'd0;
    end
    return s[1:0];
  endfunction

  function automatic logic [23:0] palette(input logic [1:0] b);
    logic [23:0] c;
    case (b)
      2'd0:    c = 24'hFF0000;
      2'd1:    c = 24'h0000FF;
      2'd2:    c = 24'h00FF00;
      default: c = 24'hFFFFFF;
    endcase
    return c;
  endfunction

  assign vsync_rise  = bus.vga_vsync & ~vsync_prev_q;
  assign end_of_line = (x_q == X_LAST);
  assign last_pixel  = end_of_line && (y_q == Y_LAST);

`ifdef BAND_SCROLL_EN
  assign start_next = band_inc(start_band_q);
`else
  assign start_next = start_band_q;
`endif

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    line_d       = line_q;
    band_d       = band_q;
    start_band_d = start_band_q;
    rgb_d        = rgb_q;
    frame_done_d = frame_done_q;
    vsync_prev_d = vsync_prev_q;

    if (bus.clk_pixel_ena) begin
      vsync_prev_d = bus.vga_vsync;
      frame_done_d = 1'b0;
      // A vsync edge wins over a same-cycle fetch: that pixel is dropped and rgb holds.
      if (vsync_rise) begin
        x_d    = '0;
        y_d    = '0;
        line_d = '0;
        band_d = start_band_q;
      end else if (bus.fetch_next) begin
        rgb_d = palette(band_q);
        if (!end_of_line) begin
          x_d = x_q + C_BITS_X'(1);
        end else begin
          x_d = '0;
          if (last_pixel) begin
            y_d          = '0;
            line_d       = '0;
            band_d       = start_next;
            start_band_d = start_next;
            frame_done_d = 1'b1;
          end else begin
            y_d = y_q + C_BITS_Y'(1);
            if (line_q == L_LAST) begin
              line_d = '0;
              band_d = band_inc(band_q);
            end else begin
              line_d = line_q + LW'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      x_q          <= '0;
      y_q          <= '0;
      line_q       <= '0;
      band_q       <= '0;
      start_band_q <= '0;
      rgb_q        <= '0;
      frame_done_q <= 1'b0;
      vsync_prev_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      line_q       <= line_d;
      band_q       <= band_d;
      start_band_q <= start_band_d;
      rgb_q        <= rgb_d;
      frame_done_q <= frame_done_d;
      vsync_prev_q <= vsync_prev_d;
    end
  end

  assign bus.out_red        = rgb_q[23:16];
  assign bus.out_green      = rgb_q[15:8];
  assign bus.out_blue       = rgb_q[7:0];
  assign bus.out_band       = band_q;
  assign bus.out_x          = x_q;
  assign bus.out_y          = y_q;
  assign bus.out_frame_done = frame_done_q;

endmodule

// File: tb/tb_vga_band_pattern.sv
// Bench for vga_band_pattern: two configurations driven in lockstep, directed tables plus a random run
// checked against a pixel-index reference model.
module tb_vga_band_pattern;

`ifdef BAND_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] WHITE = 24'hFFFFFF;

  logic clk;
  logic rst_n;
  logic ena, fetch, vsync;

  int n_cmp  = 0;
  int n_fail = 0;

  vga_band_pattern_if #(.C_BITS_X(11), .C_BITS_Y(11)) ia ();
  vga_band_pattern_if #(.C_BITS_X(11), .C_BITS_Y(11)) ib ();

  assign ia.clk_pixel_ena = ena;
  assign ia.fetch_next    = fetch;
  assign ia.vga_vsync     = vsync;
  assign ib.clk_pixel_ena = ena;
  assign ib.fetch_next    = fetch;
  assign ib.vga_vsync     = vsync;

  vga_band_pattern #(.C_RES_X(8), .C_RES_Y(4), .C_BAND_LINES(2), .C_NUM_COLORS(2),
                     .C_BITS_X(11), .C_BITS_Y(11))
    dut_a (.clk_pixel(clk), .rst_n(rst_n), .bus(ia));

  vga_band_pattern #(.C_RES_X(4), .C_RES_Y(5), .C_BAND_LINES(1), .C_NUM_COLORS(4),
                     .C_BITS_X(11), .C_BITS_Y(11))
    dut_b (.clk_pixel(clk), .rst_n(rst_n), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position is a pixel index within the frame; band derives from y and the frame's start band.
  int rx[2] = '{8, 4};
  int ry[2] = '{4, 5};
  int bl[2] = '{2, 1};
  int nc[2] = '{2, 4};
  int mn[2];
  int mst[2];
  logic [23:0] mrgb[2];
  bit mfd[2];
  bit mvp[2];

  function automatic logic [23:0] pal(input int b);
    case (b)
      0:       return RED;
      1:       return BLUE;
      2:       return GREEN;
      default: return WHITE;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mn[i] = 0; mst[i] = 0; mrgb[i] = '0; mfd[i] = 0; mvp[i] = 0;
    end
  endtask

  task automatic model_clk();
    bit rise;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mn[i] = 0; mst[i] = 0; mrgb[i] = '0; mfd[i] = 0; mvp[i] = 0;
      end else if (ena) begin
        rise   = vsync && !mvp[i];
        mvp[i] = vsync;
        mfd[i] = 0;
        if (rise) begin
          mn[i] = 0;
        end else if (fetch) begin
          mrgb[i] = pal((mst[i] + (mn[i] / rx[i]) / bl[i]) % nc[i]);
          mn[i]++;
          if (mn[i] == rx[i] * ry[i]) begin
            mn[i]  = 0;
            mfd[i] = 1;
            if (SCROLL) mst[i] = (mst[i] + 1) % nc[i];
          end
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic f, input logic v);
    ena = e; fetch = f; vsync = v;
    @(posedge clk);
    #1;
    model_clk();
  endtask

  task automatic do_reset();
    ena = 1'b0; fetch = 1'b0; vsync = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_model(input int i, input logic [10:0] x, input logic [10:0] y,
                           input logic [1:0] band, input logic [23:0] rgb, input logic fd);
    string s;
    s = (i == 0) ? "a" : "b";
    chk({"rnd_x_", s},    32'(x),    32'(mn[i] % rx[i]));
    chk({"rnd_y_", s},    32'(y),    32'(mn[i] / rx[i]));
    chk({"rnd_band_", s}, 32'(band), 32'((mst[i] + (mn[i] / rx[i]) / bl[i]) % nc[i]));
    chk({"rnd_rgb_", s},  32'(rgb),  32'(mrgb[i]));
    chk({"rnd_fd_", s},   32'(fd),   32'(mfd[i]));
  endtask

  typedef struct {
    int          rep;
    logic        e, f, v;
    logic [10:0] x, y;
    logic [1:0]  band;
    logic [23:0] rgb;
    logic        fd;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [23:0] line_col[5];
    logic [23:0] exp_rgb;

    line_col = '{RED, BLUE, GREEN, WHITE, RED};

    // Config A (8x4, 2-line bands, 2 colours): gating, resync and frame wrap.
    tbl[0]  = '{1,  1'b1, 1'b1, 1'b0, 11'd1, 11'd0, 2'd0, RED,  1'b0};
    tbl[1]  = '{5,  1'b0, 1'b1, 1'b0, 11'd1, 11'd0, 2'd0, RED,  1'b0};
    tbl[2]  = '{1,  1'b1, 1'b0, 1'b0, 11'd1, 11'd0, 2'd0, RED,  1'b0};
    tbl[3]  = '{9,  1'b1, 1'b1, 1'b0, 11'd2, 11'd1, 2'd0, RED,  1'b0};
    tbl[4]  = '{1,  1'b1, 1'b1, 1'b0, 11'd3, 11'd1, 2'd0, RED,  1'b0};
    tbl[5]  = '{1,  1'b1, 1'b1, 1'b1, 11'd0, 11'd0, 2'd0, RED,  1'b0};
    tbl[6]  = '{1,  1'b1, 1'b1, 1'b1, 11'd1, 11'd0, 2'd0, RED,  1'b0};
    tbl[7]  = '{15, 1'b1, 1'b1, 1'b0, 11'd0, 11'd2, 2'd1, RED,  1'b0};
    tbl[8]  = '{1,  1'b1, 1'b1, 1'b0, 11'd1, 11'd2, 2'd1, BLUE, 1'b0};
    tbl[9]  = '{1,  1'b0, 1'b0, 1'b1, 11'd1, 11'd2, 2'd1, BLUE, 1'b0};
    tbl[10] = '{1,  1'b1, 1'b0, 1'b1, 11'd0, 11'd0, 2'd0, BLUE, 1'b0};
    tbl[11] = '{1,  1'b1, 1'b1, 1'b0, 11'd1, 11'd0, 2'd0, RED,  1'b0};
    tbl[12] = '{31, 1'b1, 1'b1, 1'b0, 11'd0, 11'd0, SCROLL ? 2'd1 : 2'd0, BLUE, 1'b1};

    // Reset state
    rst_n = 1'b0; ena = 1'b1; fetch = 1'b0; vsync = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x",    32'(ia.out_x), 0);
    chk("rst_y",    32'(ia.out_y), 0);
    chk("rst_band", 32'(ia.out_band), 0);
    chk("rst_rgb",  32'({ia.out_red, ia.out_green, ia.out_blue}), 0);
    chk("rst_fd",   32'(ia.out_frame_done), 0);
    rst_n = 1'b1;

    // Asynchronous reset mid-frame, between clock edges
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);
    chk("pre_rst_y", 32'(ia.out_y), 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_x",    32'(ia.out_x), 0);
    chk("arst_y",    32'(ia.out_y), 0);
    chk("arst_band", 32'(ia.out_band), 0);
    chk("arst_rgb",  32'({ia.out_red, ia.out_green, ia.out_blue}), 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'(i % 2), 1'b0);
    chk("in_rst_x", 32'(ia.out_x), 0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    chk("post_rst_rgb", 32'({ia.out_red, ia.out_green, ia.out_blue}), 32'(RED));
    chk("post_rst_x",   32'(ia.out_x), 1);
    chk("post_rst_y",   32'(ia.out_y), 0);

    // Band walk on A, palette on B
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b1, 1'b0);
      exp_rgb = (i / 8 < 2) ? RED : BLUE;
      chk("walk_rgb_a", 32'({ia.out_red, ia.out_green, ia.out_blue}), 32'(exp_rgb));
      if (i < 31) chk("walk_fd_a", 32'(ia.out_frame_done), 0);
      if (i < 20) chk("pal_rgb_b", 32'({ib.out_red, ib.out_green, ib.out_blue}), 32'(line_col[i / 4]));
      if (i == 19) chk("pal_fd_b", 32'(ib.out_frame_done), 1);
    end
    chk("walk_end_fd",   32'(ia.out_frame_done), 1);
    chk("walk_end_x",    32'(ia.out_x), 0);
    chk("walk_end_y",    32'(ia.out_y), 0);
    chk("walk_end_band", 32'(ia.out_band), SCROLL ? 1 : 0);
    step(1'b1, 1'b0, 1'b0);
    chk("walk_fd_drop", 32'(ia.out_frame_done), 0);

    // Frame-to-frame start colour
    for (int f = 1; f <= 3; f++) begin
      step(1'b1, 1'b1, 1'b0);
      exp_rgb = (SCROLL && (f % 2 == 1)) ? BLUE : RED;
      chk("frame_start_rgb", 32'({ia.out_red, ia.out_green, ia.out_blue}), 32'(exp_rgb));
      for (int i = 1; i < 32; i++) step(1'b1, 1'b1, 1'b0);
    end

    // Table of gating / resync vectors
    do_reset();
    for (int r = 0; r < 13; r++) begin
      for (int k = 0; k < tbl[r].rep; k++) step(tbl[r].e, tbl[r].f, tbl[r].v);
      chk($sformatf("tbl%0d_x", r),    32'(ia.out_x),    32'(tbl[r].x));
      chk($sformatf("tbl%0d_y", r),    32'(ia.out_y),    32'(tbl[r].y));
      chk($sformatf("tbl%0d_band", r), 32'(ia.out_band), 32'(tbl[r].band));
      chk($sformatf("tbl%0d_rgb", r),  32'({ia.out_red, ia.out_green, ia.out_blue}), 32'(tbl[r].rgb));
      chk($sformatf("tbl%0d_fd", r),   32'(ia.out_frame_done), 32'(tbl[r].fd));
    end

    // Random run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) < 2));
      chk_model(0, ia.out_x, ia.out_y, ia.out_band, {ia.out_red, ia.out_green, ia.out_blue}, ia.out_frame_done);
      chk_model(1, ib.out_x, ib.out_y, ib.out_band, {ib.out_red, ib.out_green, ib.out_blue}, ib.out_frame_done);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
